// File: rtl/blit_pkg.sv
// Shared constants and FSM state type for the sprite blitter.
// Frame buffer geometry is 640x480 with 5-bit palette indices.
// Index 0 is the transparent colour and is never written.
package blit_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int FB_AW    = 19;
  localparam int PIX_W    = 5;

  localparam logic [PIX_W-1:0] TRANSPARENT_IDX = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } blit_state_t;

endpackage

// File: rtl/blit_addr_gen.sv
// Read-side walker: col/row counters, ROM row accumulator, frame-buffer row base.
// Addresses and coordinates are combinational from registers; one pixel per step.
// Optional horizontal mirror when SPRITE_BLITTER_HFLIP_EN is defined.
module blit_addr_gen
  import blit_pkg::*;
#(
  parameter int ROM_AW = 16,
  parameter int DIM_W  = 7
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    load_i,
  input  logic                    step_i,
  input  logic [ROM_AW-1:0]       base_i,
  input  logic [DIM_W-1:0]        w_i,
  input  logic [DIM_W-1:0]        h_i,
  input  logic signed [10:0]      dst_x_i,
  input  logic signed [10:0]      dst_y_i,
  input  logic                    hflip_i,
  output logic [ROM_AW-1:0]       rom_addr_o,
  output logic signed [10:0]      x_o,
  output logic signed [10:0]      y_o,
  output logic [FB_AW-1:0]        fb_row_o,
  output logic                    last_o
);

  localparam logic [DIM_W-1:0] ONE        = DIM_W'(1);
  localparam logic [FB_AW-1:0] ROW_STRIDE = FB_AW'(SCREEN_W);

  logic [DIM_W-1:0]   w_q, h_q, col_q, col_d, row_q, row_d, coff;
  logic [ROM_AW-1:0]  rom_row_q, rom_row_d;
  logic [FB_AW-1:0]   fb_row_q, fb_row_d, y_ext;
  logic signed [10:0] dst_x_q, dst_y_q, col_s, row_s;
  logic               col_end;

  assign col_end = (col_q == w_q - ONE);
  assign last_o  = col_end && (row_q == h_q - ONE);
  // Row base y*640 built as (y<<9)+(y<<7) from the sign-extended start row.
  assign y_ext   = {{(FB_AW-11){dst_y_i[10]}}, dst_y_i};

  // Next-state for the walk: reload on accept, advance one pixel per step.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    rom_row_d = rom_row_q;
    fb_row_d  = fb_row_q;
    if (load_i) begin
      col_d     = '0;
      row_d     = '0;
      rom_row_d = base_i;
      fb_row_d  = (y_ext << 9) + (y_ext << 7);
    end else if (step_i) begin
      if (col_end) begin
        col_d     = '0;
        row_d     = row_q + ONE;
        rom_row_d = rom_row_q + {{(ROM_AW-DIM_W){1'b0}}, w_q};
        fb_row_d  = fb_row_q + ROW_STRIDE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  // Walk state plus blit parameters captured at accept.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      col_q     <= '0;
      row_q     <= '0;
      rom_row_q <= '0;
      fb_row_q  <= '0;
      w_q       <= '0;
      h_q       <= '0;
      dst_x_q   <= '0;
      dst_y_q   <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      rom_row_q <= rom_row_d;
      fb_row_q  <= fb_row_d;
      if (load_i) begin
        w_q     <= w_i;
        h_q     <= h_i;
        dst_x_q <= dst_x_i;
        dst_y_q <= dst_y_i;
      end
    end
  end

`ifdef SPRITE_BLITTER_HFLIP_EN
  logic             flip_q;
  logic [DIM_W-1:0] coff_q, coff_d;

  // Mirrored column offset counts down from w-1 when flipping.
  always_comb begin
    coff_d = coff_q;
    if (load_i) begin
      coff_d = hflip_i ? (w_i - ONE) : '0;
    end else if (step_i) begin
      if (col_end)     coff_d = flip_q ? (w_q - ONE) : '0;
      else if (flip_q) coff_d = coff_q - ONE;
      else             coff_d = coff_q + ONE;
    end
  end

  // Flip request is captured at accept and held for the whole blit.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flip_q <= 1'b0;
      coff_q <= '0;
    end else begin
      coff_q <= coff_d;
      if (load_i) flip_q <= hflip_i;
    end
  end

  assign coff = coff_q;
`else
  logic unused_hflip;
  assign unused_hflip = hflip_i;
  assign coff         = col_q;
`endif

  assign col_s      = {{(11-DIM_W){1'b0}}, col_q};
  assign row_s      = {{(11-DIM_W){1'b0}}, row_q};
  assign x_o        = dst_x_q + col_s;
  assign y_o        = dst_y_q + row_s;
  assign fb_row_o   = fb_row_q;
  assign rom_addr_o = rom_row_q + {{(ROM_AW-DIM_W){1'b0}}, coff};

endmodule

// File: rtl/sprite_blitter.sv
// Copies a sprite from ROM into the 640x480 frame buffer, clipping and skipping index 0.
// Latency: ROM read in cycle 1+k, frame-buffer write in cycle 2+k, done in cycle N+2.
// No backpressure: one pixel per cycle; start is ignored unless IDLE. Option: SPRITE_BLITTER_HFLIP_EN.
module sprite_blitter
  import blit_pkg::*;
#(
  parameter int ROM_AW = 16,
  parameter int DIM_W  = 7
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                start,
  input  logic [ROM_AW-1:0]   sprite_base,
  input  logic [DIM_W-1:0]    sprite_w,
  input  logic [DIM_W-1:0]    sprite_h,
  input  logic signed [10:0]  dst_x,
  input  logic signed [10:0]  dst_y,
  input  logic                hflip,
  output logic                busy,
  output logic                done,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [PIX_W-1:0]    rom_data,
  output logic [FB_AW-1:0]    fb_write_address,
  output logic [PIX_W-1:0]    fb_data_In,
  output logic                fb_we
);

  blit_state_t        state_q;
  logic               busy_q, done_q;
  logic               wr_vld_q, wr_ok_q;
  logic [FB_AW-1:0]   fb_addr_q, fb_addr_d, fb_row;
  logic signed [10:0] x_w, y_w;
  logic               accept, zero_size, load, step, last, in_range;

  assign accept    = (state_q == IDLE) && start;
  assign zero_size = (sprite_w == '0) || (sprite_h == '0);
  assign load      = accept && !zero_size;
  assign step      = (state_q == RUN);

  blit_addr_gen #(.ROM_AW(ROM_AW), .DIM_W(DIM_W)) u_addr_gen (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .load_i     (load),
    .step_i     (step),
    .base_i     (sprite_base),
    .w_i        (sprite_w),
    .h_i        (sprite_h),
    .dst_x_i    (dst_x),
    .dst_y_i    (dst_y),
    .hflip_i    (hflip),
    .rom_addr_o (rom_addr),
    .x_o        (x_w),
    .y_o        (y_w),
    .fb_row_o   (fb_row),
    .last_o     (last)
  );

  // Control FSM with registered busy/done.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          if (zero_size) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN:   if (last) state_q <= DRAIN;
        DRAIN: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_range  = (x_w >= 11'sd0) && (x_w <= 11'sd639) &&
                     (y_w >= 11'sd0) && (y_w <= 11'sd479);
  assign fb_addr_d = fb_row + {{(FB_AW-11){x_w[10]}}, x_w};

  // Write stage: carries the clip decision and address alongside the ROM read.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_vld_q  <= 1'b0;
      wr_ok_q   <= 1'b0;
      fb_addr_q <= '0;
    end else begin
      wr_vld_q <= step;
      wr_ok_q  <= step && in_range;
      if (step) fb_addr_q <= fb_addr_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign fb_write_address = fb_addr_q;
  assign fb_data_In       = wr_vld_q ? rom_data : '0;
  assign fb_we            = wr_ok_q && (rom_data != TRANSPARENT_IDX);

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;

  logic               Clk = 1'b0;
  logic               Reset_n;
  logic               start;
  logic [15:0]        sprite_base;
  logic [6:0]         sprite_w, sprite_h;
  logic signed [10:0] dst_x, dst_y;
  logic               hflip;
  logic               busy, done;
  logic [15:0]        rom_addr;
  logic [4:0]         rom_data;
  logic [18:0]        fb_write_address;
  logic [4:0]         fb_data_In;
  logic               fb_we;

  logic [4:0] mem [0:65535];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  // One-cycle-latency sprite ROM.
  always @(posedge Clk) rom_data <= mem[rom_addr];

  sprite_blitter #(.ROM_AW(16), .DIM_W(7)) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .start            (start),
    .sprite_base      (sprite_base),
    .sprite_w         (sprite_w),
    .sprite_h         (sprite_h),
    .dst_x            (dst_x),
    .dst_y            (dst_y),
    .hflip            (hflip),
    .busy             (busy),
    .done             (done),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .fb_write_address (fb_write_address),
    .fb_data_In       (fb_data_In),
    .fb_we            (fb_we)
  );

  typedef struct {
    int              w, h, base, dx, dy;
    int              hole;       // ROM address forced transparent, -1 for none
    bit              repulse;    // pulse start again in cycle 3
    int              exp_n;      // expected number of writes
    int              exp_done;   // expected done cycle
    logic [7:0][18:0] wa;        // expected write addresses in order
    logic [7:0][7:0]  wc;        // expected write cycles in order
  } vec_t;

  localparam int NV = 8;
  vec_t tv [NV];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int v, input int w, input int h, input int base,
                         input int dx, input int dy, input int hole, input bit rp,
                         input int exp_done);
    tv[v].w = w; tv[v].h = h; tv[v].base = base; tv[v].dx = dx; tv[v].dy = dy;
    tv[v].hole = hole; tv[v].repulse = rp; tv[v].exp_done = exp_done;
    tv[v].exp_n = 0; tv[v].wa = '0; tv[v].wc = '0;
  endtask

  task automatic add_wr(input int v, input int addr, input int cyc);
    tv[v].wa[tv[v].exp_n] = 19'(addr);
    tv[v].wc[tv[v].exp_n] = 8'(cyc);
    tv[v].exp_n++;
  endtask

  task automatic fill_rom(input int hole);
    for (int a = 0; a < 8192; a++) mem[a] = 5'd3;
    if (hole >= 0) mem[hole] = 5'd0;
  endtask

  task automatic run_vec(input int v);
    int n, nwr, ndone, first_done;
    bit exp_busy;
    fill_rom(tv[v].hole);
    @(negedge Clk);
    sprite_base = 16'(tv[v].base);
    sprite_w    = 7'(tv[v].w);
    sprite_h    = 7'(tv[v].h);
    dst_x       = 11'(tv[v].dx);
    dst_y       = 11'(tv[v].dy);
    hflip       = 1'b0;
    start       = 1'b1;
    n = tv[v].w * tv[v].h;
    nwr = 0; ndone = 0; first_done = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      start = (tv[v].repulse && c == 3);
      if (c <= n) chk($sformatf("v%0d rom_addr c%0d", v, c), rom_addr, tv[v].base + c - 1);
      exp_busy = (n > 0) && (c <= n + 1);
      chk($sformatf("v%0d busy c%0d", v, c), busy, exp_busy);
      if (fb_we) begin
        if (nwr < tv[v].exp_n) begin
          chk($sformatf("v%0d wr%0d addr", v, nwr), fb_write_address, tv[v].wa[nwr]);
          chk($sformatf("v%0d wr%0d cycle", v, nwr), c, tv[v].wc[nwr]);
          chk($sformatf("v%0d wr%0d data", v, nwr), fb_data_In, 3);
        end
        nwr++;
      end
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
    end
    chk($sformatf("v%0d write_count", v), nwr, tv[v].exp_n);
    chk($sformatf("v%0d done_count", v), ndone, 1);
    chk($sformatf("v%0d done_cycle", v), first_done, tv[v].exp_done);
  endtask

  initial begin
    int exp_ra, ndone;

    // 4x2 at (10,5), all opaque
    set_vec(0, 4, 2, 'h100, 10, 5, -1, 0, 10);
    for (int k = 0; k < 4; k++) add_wr(0, 3210 + k, 2 + k);
    for (int k = 0; k < 4; k++) add_wr(0, 3850 + k, 6 + k);
    // same with pixel (1,0) transparent
    set_vec(1, 4, 2, 'h100, 10, 5, 'h101, 0, 10);
    add_wr(1, 3210, 2); add_wr(1, 3212, 4); add_wr(1, 3213, 5);
    for (int k = 0; k < 4; k++) add_wr(1, 3850 + k, 6 + k);
    // left clip
    set_vec(2, 4, 1, 'h200, -2, 0, -1, 0, 6);
    add_wr(2, 0, 4); add_wr(2, 1, 5);
    // bottom-right corner clip
    set_vec(3, 4, 1, 'h200, 638, 479, -1, 0, 6);
    add_wr(3, 307198, 2); add_wr(3, 307199, 3);
    // 1x1 minimum sprite
    set_vec(4, 1, 1, 'h010, 0, 0, -1, 0, 3);
    add_wr(4, 0, 2);
    // top and right clip together
    set_vec(5, 2, 2, 'h020, 639, -1, -1, 0, 6);
    add_wr(5, 639, 4);
    // zero-width sprite
    set_vec(6, 0, 3, 'h000, 0, 0, -1, 0, 1);
    // start re-pulsed mid-blit is ignored
    set_vec(7, 4, 2, 'h100, 10, 5, -1, 1, 10);
    for (int k = 0; k < 4; k++) add_wr(7, 3210 + k, 2 + k);
    for (int k = 0; k < 4; k++) add_wr(7, 3850 + k, 6 + k);

    Reset_n = 1'b0; start = 1'b0; sprite_base = '0; sprite_w = '0; sprite_h = '0;
    dst_x = '0; dst_y = '0; hflip = 1'b0;
    fill_rom(-1);
    repeat (2) @(negedge Clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset fb_we", fb_we, 0);
    chk("reset rom_addr", rom_addr, 0);
    chk("reset fb_addr", fb_write_address, 0);
    chk("reset fb_data", fb_data_In, 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    for (int v = 0; v < NV; v++) run_vec(v);

    // Horizontal flip addressing
    fill_rom(-1);
    @(negedge Clk);
    sprite_base = '0; sprite_w = 7'd4; sprite_h = 7'd1; dst_x = '0; dst_y = '0;
    hflip = 1'b1; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      start = 1'b0;
`ifdef SPRITE_BLITTER_HFLIP_EN
      exp_ra = 4 - c;
`else
      exp_ra = c - 1;
`endif
      chk($sformatf("hflip rom_addr c%0d", c), rom_addr, exp_ra);
    end
    repeat (6) @(negedge Clk);
    hflip = 1'b0;

    // Reset in cycle 4 of a 64x64 blit
    @(negedge Clk);
    sprite_base = '0; sprite_w = 7'd64; sprite_h = 7'd64; dst_x = '0; dst_y = '0;
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      start = 1'b0;
    end
    chk("abort we_before", fb_we, 1);
    chk("abort busy_before", busy, 1);
    Reset_n = 1'b0;
    #1;
    chk("abort fb_we", fb_we, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (done) ndone++;
    end
    chk("abort no_done", ndone, 0);
    chk("abort idle_busy", busy, 0);
    run_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Upstream writer for the 640x480, 5-bit palette-index frame buffer. On a start pulse it copies one rectangular sprite from the sprite ROM into the frame buffer at a signed screen position. Transparent pixels (index 0) are skipped and off-screen pixels are clipped, which supports scrolling and partially visible sprites. Throughput is one pixel per cycle, and its write-side ports connect directly to the frame buffer's write port.

## Interface
Parameters:
- ROM_AW, 16, sprite ROM address width
- DIM_W, 7, width of sprite_w/sprite_h (sprites up to 64x64)

Ports:
- Clk  in  1  system clock; all logic on posedge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a blit; sampled only in IDLE
- sprite_base  in  ROM_AW  ROM address of sprite pixel (0,0), row-major
- sprite_w, sprite_h  in  DIM_W  sprite dimensions in pixels
- dst_x, dst_y  in  11 (signed)  screen position of the sprite's top-left corner
- hflip  in  1  horizontal mirror request (see Configuration)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the blit completes
- rom_addr  out  ROM_AW  sprite ROM read address; data returns 1 cycle later
- rom_data  in  5  sprite ROM pixel
- fb_write_address  out  19  frame buffer address, y*640+x
- fb_data_In  out  5  pixel written to the frame buffer
- fb_we  out  1  frame buffer write enable

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start=1. All inputs are latched in that cycle. If sprite_w==0 or sprite_h==0, the transition is IDLE -> DONE instead.
- RUN:
  - Issues rom_addr for pixel (col,row), walking col 0..w-1 within row 0..h-1.
  - rom_addr = sprite_base + row*w + col. Without flip, col is used directly; with flip, col is replaced by w-1-col.
  - The row offset comes from a running accumulator (add w per row). No multiplier is used.
  - After the last pixel is issued, RUN -> DRAIN.
- Write stage, one cycle behind the read:
  - The pixel's (col,row) is pipelined alongside the read.
  - x = dst_x+col and y = dst_y+row, both 11-bit signed.
  - fb_we=1 only if rom_data != 0 and 0<=x<=639 and 0<=y<=479.
  - fb_write_address = y*640+x, computed as (y<<9)+(y<<7)+x with a running row-base register. It is truncated to 19 bits and is only meaningful when fb_we=1.
  - fb_data_In = rom_data.
- DRAIN lasts one cycle and performs the final write. Then DRAIN -> DONE.
- DONE lasts one cycle: done=1, busy=0. Then DONE -> IDLE.
- start while busy or in DONE is ignored; no queuing.
- Unsigned row/col counters are DIM_W bits; pixel coordinate adds are performed at 11-bit signed.

## Timing
- Reset values: busy=0, done=0, fb_we=0, rom_addr=0, fb_write_address=0, fb_data_In=0; state=IDLE.
- Reset asserted mid-blit aborts immediately: fb_we drops asynchronously and no done pulse is produced.
- For start in cycle 0 and N = w*h:
  - busy=1 in cycles 1..N+1.
  - rom_addr for pixel k in cycle 1+k.
  - Write opportunity for pixel k in cycle 2+k.
  - done=1 and busy=0 in cycle N+2.
- Zero-size sprite: done=1 in cycle 1, with no writes and no ROM reads.
- Earliest accepted restart: cycle N+3.

## Configuration
- SPRITE_BLITTER_HFLIP_EN:
  - Defined: hflip is latched at start and mirrors ROM column addressing.
  - Undefined: hflip is ignored (port retained) and column addressing is always direct; no flip subtractor is synthesized.

## Structure
- Package blit_pkg:
  - SCREEN_W=640, SCREEN_H=480, FB_AW=19, PIX_W=5, TRANSPARENT_IDX=5'd0
  - state enum blit_state_t
- One sub-module, blit_addr_gen: holds the col/row counters, ROM row accumulator, flip logic and frame-buffer row-base register. The top level holds the FSM, write-stage pipeline registers and clip/transparency gating.

## Test plan
- 4x2 sprite, base 0x0100, dst (10,5), ROM all 0x3 -> 8 writes at addresses 3210..3213 and 3850..3853 in cycles 2..9; done in cycle 10.
- Same sprite with ROM pixel (1,0)=0 -> no write to 3211; the other 7 are written; timing unchanged.
- 4x1 sprite at dst (-2,0) -> only cols 2,3 are written, at addresses 0,1. At dst (638,479) -> writes at 307198 and 307199 only.
- hflip=1 with the macro defined, 4x1 sprite, base 0 -> rom_addr sequence 3,2,1,0. With the macro undefined -> 0,1,2,3.
- start pulsed again in cycle 3 of a blit -> ignored: exactly one done, writes unaffected. sprite_w=0 -> done in cycle 1, fb_we never asserted.
- Reset_n pulsed low in cycle 4 of a 64x64 blit -> fb_we=0 immediately, busy=0, no done. A new start after release completes normally.
